// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: programmable four-phase square-wave sequencer.
// A 4-entry phase table (length, level) is played for a latched number of passes
// (0 = run until stopped) with a busy/done handshake. Reset defaults give the
// legacy 10-high / 10-low / 10-high / 10-low pattern.
// Optional macro PULSE_SEQ_DBG_EN: when defined, sq_i/sq_c expose the live phase
// index and in-phase counter; otherwise both are tied to 0.
module pulse_seq_ctrl #(
    parameter int CW = 5,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_idx,
    input  logic [CW-1:0] cfg_len,
    input  logic          cfg_lvl,
    input  logic [RW-1:0] rep,
    input  logic          start,
    input  logic          stop,
    output logic          q,
    output logic          busy,
    output logic          done,
    output logic [1:0]    sq_i,
    output logic [CW-1:0] sq_c
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef logic [3:0][CW-1:0] len_tbl_t;

    localparam logic [CW-1:0] DEF_LEN = CW'(10);
    localparam logic [3:0]    DEF_LVL = 4'b0101;  // entries 0 and 2 high

    state_t        r_state, w_state_nxt;
    len_tbl_t      r_len, w_len_nxt;
    logic [3:0]    r_lvl, w_lvl_nxt;
    logic [1:0]    r_idx, w_idx_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [RW-1:0] r_pass, w_pass_nxt;
    logic [RW-1:0] r_rep, w_rep_nxt;
    logic          r_stop_pend, w_stop_pend_nxt;
    logic          r_q, w_q_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic [3:0]    w_nz;
    logic [2:0]    w_pick;
    logic [RW-1:0] w_pass_inc;

    // Bit j set when table entry j has a nonzero length.
    function automatic logic [3:0] nz_mask(input len_tbl_t t);
        logic [3:0] m;
        for (int j = 0; j < 4; j++) m[j] = |t[j];
        return m;
    endfunction

    // Lowest nonzero phase with index >= from; returns {found, index}.
    function automatic logic [2:0] pick_phase(input logic [3:0] nz, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int j = 3; j >= 0; j--)
            if (nz[j] && (3'(j) >= from)) res = {1'b1, 2'(j)};
        return res;
    endfunction

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        // NOTE: every target gets a default before the case so no path can hold a
        // stale value and infer a latch.
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_lvl_nxt       = r_lvl;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_pass_nxt      = r_pass;
        w_rep_nxt       = r_rep;
        w_stop_pend_nxt = r_stop_pend;
        w_q_nxt         = r_q;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_nz            = '0;
        w_pick          = '0;
        w_pass_inc      = r_pass + RW'(1);

        case (r_state)
            S_IDLE: begin
                w_stop_pend_nxt = 1'b0;
                // A write in the start cycle lands first so the run sees it.
                if (cfg_we) begin
                    w_len_nxt[cfg_idx] = cfg_len;
                    w_lvl_nxt[cfg_idx] = cfg_lvl;
                end
                if (start) begin
                    w_rep_nxt  = rep;
                    w_pass_nxt = '0;
                    w_nz       = nz_mask(w_len_nxt);
                    w_pick     = pick_phase(w_nz, 3'd0);
                    if (w_pick[2]) begin
                        w_state_nxt = S_RUN;
                        w_idx_nxt   = w_pick[1:0];
                        w_cnt_nxt   = '0;
                        w_q_nxt     = w_lvl_nxt[w_pick[1:0]];
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            S_RUN: begin
                w_stop_pend_nxt = r_stop_pend | stop;
                w_nz            = nz_mask(r_len);
                if (r_cnt == r_len[r_idx] - CW'(1)) begin
                    w_pick = pick_phase(w_nz, {1'b0, r_idx} + 3'd1);
                    if (w_pick[2]) begin
                        w_idx_nxt = w_pick[1:0];
                        w_cnt_nxt = '0;
                        w_q_nxt   = r_lvl[w_pick[1:0]];
                    end else begin
                        // End of a pass: a stop seen on this very cycle still counts.
                        w_pass_nxt = w_pass_inc;
                        if (r_stop_pend || stop || ((r_rep != '0) && (w_pass_inc == r_rep))) begin
                            w_state_nxt = S_DONE;
                            w_idx_nxt   = '0;
                            w_cnt_nxt   = '0;
                            w_q_nxt     = 1'b0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_pick    = pick_phase(w_nz, 3'd0);
                            w_idx_nxt = w_pick[1:0];
                            w_cnt_nxt = '0;
                            w_q_nxt   = r_lvl[w_pick[1:0]];
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            S_DONE: begin
                w_state_nxt     = S_IDLE;
                w_stop_pend_nxt = 1'b0;
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, phase table and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the phase table is only four entries and reset must restore the
            // legacy pattern, so it is reset like ordinary state rather than left as
            // an uninitialised memory.
            r_state     <= S_IDLE;
            r_len       <= {4{DEF_LEN}};
            r_lvl       <= DEF_LVL;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_pass      <= '0;
            r_rep       <= '0;
            r_stop_pend <= 1'b0;
            r_q         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_lvl       <= w_lvl_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pass      <= w_pass_nxt;
            r_rep       <= w_rep_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_q         <= w_q_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;

`ifdef PULSE_SEQ_DBG_EN
    // Index and counter are cleared whenever the FSM leaves RUN, so they read 0 outside a run.
    assign sq_i = r_idx;
    assign sq_c = r_cnt;
`else
    assign sq_i = '0;
    assign sq_c = '0;
`endif

endmodule
